// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SPI SD data path: CRC polynomial, token bytes
// and the receive-side block state encoding.
package sd_spi_pkg;

  localparam logic [15:0] CRC16_POLY  = 16'h1021;
  localparam logic [7:0]  TOKEN_START = 8'hFE;
  localparam logic [7:0]  IDLE_BYTE   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HUNT  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CRC_H = 3'd3,
    ST_CRC_L = 3'd4
  } blk_state_t;

endpackage

// File: rtl/crc16_ccitt_byte_step.sv
// One-byte step of CRC16-CCITT (x^16+x^12+x^5+1), MSB first, no reflection.
// Purely combinational so the RX checker and the TX generator can share it.
module crc16_ccitt_byte_step
  import sd_spi_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  // Fold the byte into the top of the CRC, then shift out eight bits.
  always_comb begin
    logic [15:0] c;
    c = crc_in ^ {data_in, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else       c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/sd_block_crc_checker.sv
// SD read-block receiver: hunts the 0xFE start token, forwards BLOCK_LEN
// payload bytes with one cycle of latency and checks the trailing CRC16.
module sd_block_crc_checker
  import sd_spi_pkg::*;
#(
  parameter int BLOCK_LEN     = 512,
  parameter int TOKEN_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  byte_in,
  input  logic        byte_vld,
  input  logic        abort,
  output logic [7:0]  data_out,
  output logic        data_vld,
  output logic        busy,
  output logic        block_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        token_err,
  output logic        timeout,
  output logic [15:0] calc_crc
);

  localparam int BW = $clog2(BLOCK_LEN + 1);
  localparam int HW = $clog2(TOKEN_TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BLOCK_LEN - 1);
  localparam logic [HW-1:0] LAST_HUNT = HW'(TOKEN_TIMEOUT - 1);

  blk_state_t    state, state_nxt;
  logic [BW-1:0] byte_cnt;
  logic [HW-1:0] hunt_cnt;
  logic [15:0]   crc_p0;
  logic [15:0]   crc_step;
  logic [7:0]    rx_crc_h;

  logic tok_hit, ff_hit, pay_hit, crch_hit, done_hit, tokerr_hit, to_hit;
  logic match;

  crc16_ccitt_byte_step u_crc_step (
    .crc_in  (crc_p0),
    .data_in (byte_in),
    .crc_out (crc_step)
  );

  assign busy  = (state != ST_IDLE);
  assign match = ({rx_crc_h, byte_in} == crc_p0);

  // State register; reset drops any partial block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state: abort wins, otherwise only accepted bytes move the FSM.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (enable) state_nxt = ST_HUNT;
        ST_HUNT:  if (byte_vld) begin
                    if (byte_in == TOKEN_START)     state_nxt = ST_DATA;
                    else if (byte_in != IDLE_BYTE)  state_nxt = ST_IDLE;
                    else if (hunt_cnt == LAST_HUNT) state_nxt = ST_IDLE;
                  end
        ST_DATA:  if (byte_vld && byte_cnt == LAST_BYTE) state_nxt = ST_CRC_H;
        ST_CRC_H: if (byte_vld) state_nxt = ST_CRC_L;
        ST_CRC_L: if (byte_vld) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Per-byte events, all masked by abort so it suppresses every pulse.
  always_comb begin
    tok_hit    = 1'b0;
    ff_hit     = 1'b0;
    pay_hit    = 1'b0;
    crch_hit   = 1'b0;
    done_hit   = 1'b0;
    tokerr_hit = 1'b0;
    to_hit     = 1'b0;
    if (!abort && byte_vld) begin
      unique case (state)
        ST_HUNT: begin
          tok_hit    = (byte_in == TOKEN_START);
          ff_hit     = (byte_in == IDLE_BYTE);
          tokerr_hit = !tok_hit && !ff_hit;
          to_hit     = ff_hit && (hunt_cnt == LAST_HUNT);
        end
        ST_DATA:  pay_hit  = 1'b1;
        ST_CRC_H: crch_hit = 1'b1;
        ST_CRC_L: done_hit = 1'b1;
        default: ;
      endcase
    end
  end

  // Counters, running CRC, received CRC capture and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hunt_cnt   <= '0;
      byte_cnt   <= '0;
      crc_p0     <= 16'h0000;
      rx_crc_h   <= 8'h00;
      data_out   <= 8'h00;
      data_vld   <= 1'b0;
      block_done <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
      token_err  <= 1'b0;
      timeout    <= 1'b0;
      calc_crc   <= 16'h0000;
    end else begin
      data_vld   <= pay_hit;
      block_done <= done_hit;
      token_err  <= tokerr_hit;
      timeout    <= to_hit;

      // Hunt counter restarts every time the block returns to IDLE.
      if (state == ST_IDLE) hunt_cnt <= '0;
      else if (ff_hit)      hunt_cnt <= hunt_cnt + 1'b1;

      if (tok_hit) begin
        byte_cnt <= '0;
        crc_p0   <= 16'h0000;
      end else if (pay_hit) begin
        byte_cnt <= byte_cnt + 1'b1;
        crc_p0   <= crc_step;
      end

      if (pay_hit)  data_out <= byte_in;
      if (crch_hit) rx_crc_h <= byte_in;

      if (abort || tok_hit) begin
        crc_ok  <= 1'b0;
        crc_err <= 1'b0;
      end else if (done_hit) begin
        crc_ok   <= match;
        crc_err  <= !match;
        calc_crc <= crc_p0;
      end
    end
  end

endmodule

// File: tb/tb_sd_block_crc_checker.sv
// Directed bench for sd_block_crc_checker: a 512-byte instance (A) and a
// 9-byte / short-timeout instance (B) driven from one linear sequence.
module tb_sd_block_crc_checker;

  logic clk = 1'b0;
  logic rst;

  logic        a_enable, a_vld, a_abort;
  logic [7:0]  a_byte;
  logic [7:0]  a_data_out;
  logic        a_data_vld, a_busy, a_done, a_ok, a_err, a_tokerr, a_to;
  logic [15:0] a_calc;

  logic        b_enable, b_vld, b_abort;
  logic [7:0]  b_byte;
  logic [7:0]  b_data_out;
  logic        b_data_vld, b_busy, b_done, b_ok, b_err, b_tokerr, b_to;
  logic [15:0] b_calc;

  int n_asserts = 0;
  int n_fail    = 0;

  int a_data_cnt = 0, a_done_cnt = 0;
  int b_data_cnt = 0, b_data_sum = 0, b_tok_cnt = 0, b_to_cnt = 0;
  int snap0, snap1, snap2;

  always #5 clk = ~clk;

  sd_block_crc_checker #(.BLOCK_LEN(512), .TOKEN_TIMEOUT(1024)) u_dut_a (
    .clk(clk), .rst(rst), .enable(a_enable), .byte_in(a_byte), .byte_vld(a_vld),
    .abort(a_abort), .data_out(a_data_out), .data_vld(a_data_vld), .busy(a_busy),
    .block_done(a_done), .crc_ok(a_ok), .crc_err(a_err), .token_err(a_tokerr),
    .timeout(a_to), .calc_crc(a_calc)
  );

  sd_block_crc_checker #(.BLOCK_LEN(9), .TOKEN_TIMEOUT(4)) u_dut_b (
    .clk(clk), .rst(rst), .enable(b_enable), .byte_in(b_byte), .byte_vld(b_vld),
    .abort(b_abort), .data_out(b_data_out), .data_vld(b_data_vld), .busy(b_busy),
    .block_done(b_done), .crc_ok(b_ok), .crc_err(b_err), .token_err(b_tokerr),
    .timeout(b_to), .calc_crc(b_calc)
  );

  // Event monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (a_data_vld) a_data_cnt++;
    if (a_done)     a_done_cnt++;
    if (b_data_vld) begin
      b_data_cnt++;
      b_data_sum += int'(b_data_out);
    end
    if (b_tokerr)   b_tok_cnt++;
    if (b_to)       b_to_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one byte for one cycle, then idle for gap cycles.
  task automatic send(input int sel, input logic [7:0] b, input int gap);
    if (sel == 0) begin a_byte = b; a_vld = 1'b1; end
    else          begin b_byte = b; b_vld = 1'b1; end
    @(posedge clk);
    #1;
    a_vld = 1'b0;
    b_vld = 1'b0;
    tick(gap);
  endtask

  initial begin
    rst = 1'b0;
    a_enable = 1'b0; a_vld = 1'b0; a_abort = 1'b0; a_byte = 8'h00;
    b_enable = 1'b0; b_vld = 1'b0; b_abort = 1'b0; b_byte = 8'h00;
    #12;
    chk("reset_busy",  32'(a_busy),     32'h0);
    chk("reset_done",  32'(a_done),     32'h0);
    chk("reset_ok",    32'(a_ok),       32'h0);
    chk("reset_err",   32'(a_err),      32'h0);
    chk("reset_dvld",  32'(a_data_vld), 32'h0);
    chk("reset_calc",  32'(a_calc),     32'h0);
    chk("reset_b_to",  32'(b_to),       32'h0);
    rst = 1'b1;
    tick(1);

    // Gap-free 512 x 0xFF block preceded by idle bytes
    a_enable = 1'b1;
    tick(1);
    chk("a_hunt_busy", 32'(a_busy), 32'h1);
    snap0 = a_data_cnt; snap1 = a_done_cnt;
    for (int i = 0; i < 3; i++) send(0, 8'hFF, 0);
    send(0, 8'hFE, 0);
    for (int i = 0; i < 512; i++) send(0, 8'hFF, 0);
    send(0, 8'h7F, 0);
    send(0, 8'hA1, 0);
    chk("a1_done",    32'(a_done), 32'h1);
    chk("a1_ok",      32'(a_ok),   32'h1);
    chk("a1_err",     32'(a_err),  32'h0);
    chk("a1_calc",    32'(a_calc), 32'h7FA1);
    chk("a1_dcount",  32'(a_data_cnt - snap0), 32'd512);
    chk("a1_dout",    32'(a_data_out), 32'hFF);
    tick(1);
    chk("a1_done_pulse", 32'(a_done), 32'h0);
    chk("a1_donecnt", 32'(a_done_cnt - snap1), 32'd1);

    // Same block with random gaps; enable drops mid-block
    snap0 = a_data_cnt;
    send(0, 8'hFE, $urandom_range(0, 5));
    chk("a2_ok_cleared", 32'(a_ok), 32'h0);
    for (int i = 0; i < 512; i++) begin
      if (i == 100) a_enable = 1'b0;
      send(0, 8'hFF, $urandom_range(0, 5));
    end
    send(0, 8'h7F, $urandom_range(0, 5));
    send(0, 8'hA1, 0);
    chk("a2_done",   32'(a_done), 32'h1);
    chk("a2_ok",     32'(a_ok),   32'h1);
    chk("a2_calc",   32'(a_calc), 32'h7FA1);
    chk("a2_dcount", 32'(a_data_cnt - snap0), 32'd512);
    tick(2);
    chk("a2_idle",   32'(a_busy), 32'h0);

    // Abort after 100 payload bytes, then a complete block
    a_enable = 1'b1;
    tick(1);
    snap0 = a_data_cnt; snap1 = a_done_cnt;
    send(0, 8'hFE, 0);
    chk("a3_ok_cleared", 32'(a_ok), 32'h0);
    for (int i = 0; i < 100; i++) send(0, 8'hFF, 0);
    a_abort = 1'b1;
    tick(1);
    a_abort = 1'b0;
    chk("a3_abort_idle",  32'(a_busy), 32'h0);
    chk("a3_abort_dvld",  32'(a_data_vld), 32'h0);
    chk("a3_abort_cnt",   32'(a_data_cnt - snap0), 32'd100);
    tick(1);
    send(0, 8'hFE, 0);
    for (int i = 0; i < 512; i++) send(0, 8'hFF, 0);
    send(0, 8'h7F, 0);
    send(0, 8'hA1, 0);
    tick(1);
    chk("a3_donecnt", 32'(a_done_cnt - snap1), 32'd1);
    chk("a3_ok",      32'(a_ok), 32'h1);
    chk("a3_dcount",  32'(a_data_cnt - snap0), 32'd612);

    // BLOCK_LEN=9 check vector "123456789"
    b_enable = 1'b1;
    tick(1);
    snap0 = b_data_cnt; snap1 = b_data_sum;
    send(1, 8'hFE, 0);
    for (int i = 0; i < 9; i++) send(1, 8'(8'h31 + i), 0);
    send(1, 8'h31, 0);
    send(1, 8'hC3, 0);
    chk("b1_done",   32'(b_done), 32'h1);
    chk("b1_ok",     32'(b_ok),   32'h1);
    chk("b1_err",    32'(b_err),  32'h0);
    chk("b1_calc",   32'(b_calc), 32'h31C3);
    chk("b1_dcount", 32'(b_data_cnt - snap0), 32'd9);
    chk("b1_dsum",   32'(b_data_sum - snap1), 32'd477);

    // Corrupted low CRC byte
    tick(1);
    send(1, 8'hFE, 0);
    for (int i = 0; i < 9; i++) send(1, 8'(8'h31 + i), 0);
    send(1, 8'h31, 0);
    send(1, 8'h00, 0);
    chk("b2_done", 32'(b_done), 32'h1);
    chk("b2_ok",   32'(b_ok),   32'h0);
    chk("b2_err",  32'(b_err),  32'h1);
    chk("b2_calc", 32'(b_calc), 32'h31C3);

    // Error token during hunt
    tick(1);
    snap0 = b_data_cnt; snap2 = b_tok_cnt;
    send(1, 8'h05, 0);
    chk("b3_tokerr",    32'(b_tokerr), 32'h1);
    chk("b3_idle",      32'(b_busy),   32'h0);
    tick(1);
    chk("b3_tok_pulse", 32'(b_tokerr), 32'h0);
    chk("b3_tokcnt",    32'(b_tok_cnt - snap2), 32'd1);
    chk("b3_no_data",   32'(b_data_cnt - snap0), 32'd0);

    // Token timeout after four idle bytes
    snap2 = b_to_cnt;
    for (int i = 0; i < 3; i++) send(1, 8'hFF, 0);
    chk("b4_no_to_yet", 32'(b_to),   32'h0);
    chk("b4_hunting",   32'(b_busy), 32'h1);
    send(1, 8'hFF, 0);
    chk("b4_timeout",   32'(b_to),   32'h1);
    chk("b4_idle",      32'(b_busy), 32'h0);
    b_enable = 1'b0;
    send(1, 8'hFF, 0);
    chk("b4_to_pulse",  32'(b_to),   32'h0);
    chk("b4_still_idle", 32'(b_busy), 32'h0);
    chk("b4_tocnt",     32'(b_to_cnt - snap2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
